// File: rtl/mdio_poll_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_poll_arbiter
//
// Clause-22 MDIO master shared between host register commands and an
// autonomous PHY status poller. It generates MDC, serializes a complete
// 65-slot frame (32 preamble, ST, OP, PHYAD, REGAD, TA, 16 data, 1 idle)
// and deserializes read data. Arbitration between host and poller is
// round-robin on ties.
//
// Ports
//   clk, rst             : single clock, synchronous active-high reset
//   host_req_*           : host command (valid/ready handshake, ready is a
//                          one-cycle accept pulse in IDLE)
//   host_rsp_valid/rdata : one-cycle completion pulse; rdata holds afterwards
//   poll_enable          : runs the poll timer
//   poll_status(_updated): last polled register value and its load pulse
//   link_up              : poll_status[2]
//   busy                 : frame in progress (FRAME or DONE)
//   mdc                  : management clock, low for first CLK_DIV cycles
//                          of each bit slot
//   mdio_tx_en/tx_data   : pin drive enable and data to the external buffer
//   mdio_rx_data         : pin input, registered as MDC rises
// -----------------------------------------------------------------------------
module mdio_poll_arbiter #(
    parameter int         CLK_DIV       = 25,
    parameter int         POLL_INTERVAL = 125000,
    parameter logic [4:0] POLL_PHY_ADDR = 5'd0,
    parameter logic [4:0] POLL_REG_ADDR = 5'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic        host_req_write,
    input  logic [4:0]  host_req_phy,
    input  logic [4:0]  host_req_reg,
    input  logic [15:0] host_req_wdata,
    output logic        host_rsp_valid,
    output logic [15:0] host_rsp_rdata,
    input  logic        poll_enable,
    output logic [15:0] poll_status,
    output logic        poll_status_updated,
    output logic        link_up,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_tx_en,
    output logic        mdio_tx_data,
    input  logic        mdio_rx_data
);

    localparam int PH_W = $clog2(2 * CLK_DIV);
    localparam int TM_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE   = PH_W'(CLK_DIV);
    localparam logic [TM_W-1:0] TM_RELOAD = TM_W'(POLL_INTERVAL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  slot_q, slot_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic        poll_pending_q, poll_pending_d;
    logic        last_grant_q, last_grant_d;    // 1 = poll was granted last
    logic        src_host_q, src_host_d;
    logic        cmd_write_q, cmd_write_d;
    logic [4:0]  cmd_phy_q, cmd_phy_d;
    logic [4:0]  cmd_reg_q, cmd_reg_d;
    logic [15:0] cmd_wdata_q, cmd_wdata_d;
    logic [15:0] rx_shift_q, rx_shift_d;
    logic        mdc_q, mdc_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0] poll_status_q, poll_status_d;
    logic        poll_upd_q, poll_upd_d;

    logic        cand_host, cand_poll;
    logic        grant_host, grant_poll;
    logic [63:0] frame_bits;
    logic [5:0]  bit_idx;

    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        phase_d        = phase_q;
        timer_d        = timer_q;
        poll_pending_d = poll_pending_q;
        last_grant_d   = last_grant_q;
        src_host_d     = src_host_q;
        cmd_write_d    = cmd_write_q;
        cmd_phy_d      = cmd_phy_q;
        cmd_reg_d      = cmd_reg_q;
        cmd_wdata_d    = cmd_wdata_q;
        rx_shift_d     = rx_shift_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        poll_status_d  = poll_status_q;
        poll_upd_d     = 1'b0;
        grant_host     = 1'b0;
        grant_poll     = 1'b0;

        // A pending poll is withdrawn the moment poll_enable drops.
        cand_host = host_req_valid;
        cand_poll = poll_pending_q & poll_enable;

        case (state_q)
            S_IDLE: begin
                // On a tie the source that did not win last time goes.
                if (cand_host && (!cand_poll || last_grant_q)) begin
                    grant_host = 1'b1;
                end else if (cand_poll) begin
                    grant_poll = 1'b1;
                end
                if (grant_host || grant_poll) begin
                    state_d      = S_FRAME;
                    slot_d       = 7'd0;
                    phase_d      = '0;
                    src_host_d   = grant_host;
                    last_grant_d = grant_poll;
                    if (grant_host) begin
                        cmd_write_d = host_req_write;
                        cmd_phy_d   = host_req_phy;
                        cmd_reg_d   = host_req_reg;
                        cmd_wdata_d = host_req_wdata;
                    end else begin
                        cmd_write_d = 1'b0;
                        cmd_phy_d   = POLL_PHY_ADDR;
                        cmd_reg_d   = POLL_REG_ADDR;
                        cmd_wdata_d = 16'hFFFF;
                    end
                end
            end
            S_FRAME: begin
                // Capture data bits as MDC rises (slot offset CLK_DIV).
                if (phase_q == PH_RISE && slot_q >= 7'd48 && slot_q <= 7'd63) begin
                    rx_shift_d = {rx_shift_q[14:0], mdio_rx_data};
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (slot_q == 7'd64) begin
                        state_d = S_DONE;
                        if (src_host_q) begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = cmd_write_q ? 16'h0000 : rx_shift_q;
                        end else begin
                            poll_upd_d    = 1'b1;
                            poll_status_d = rx_shift_q;
                        end
                    end else begin
                        slot_d = slot_q + 7'd1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Poll timer: a new expiry sets pending even on the grant cycle;
        // an expiry while already pending merges into the same request.
        if (!poll_enable) begin
            timer_d        = TM_RELOAD;
            poll_pending_d = 1'b0;
        end else begin
            if (grant_poll) begin
                poll_pending_d = 1'b0;
            end
            if (timer_q == '0) begin
                timer_d        = TM_RELOAD;
                poll_pending_d = 1'b1;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        // Pin values are registered from next-state so they switch exactly at
        // slot boundaries and drop to idle levels straight out of reset.
        frame_bits = {32'hFFFF_FFFF, 2'b01, (cmd_write_d ? 2'b01 : 2'b10),
                      cmd_phy_d, cmd_reg_d, 2'b10, cmd_wdata_d};
        bit_idx    = 6'd63 - slot_d[5:0];
        mdc_d      = (state_d == S_FRAME) && (phase_d >= PH_RISE);
        tx_en_d    = 1'b0;
        tx_data_d  = 1'b1;
        if (state_d == S_FRAME && slot_d < 7'd64 && (cmd_write_d || slot_d < 7'd46)) begin
            tx_en_d   = 1'b1;
            tx_data_d = frame_bits[bit_idx];
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            slot_q         <= 7'd0;
            phase_q        <= '0;
            timer_q        <= TM_RELOAD;
            poll_pending_q <= 1'b0;
            last_grant_q   <= 1'b1;
            src_host_q     <= 1'b0;
            cmd_write_q    <= 1'b0;
            cmd_phy_q      <= 5'd0;
            cmd_reg_q      <= 5'd0;
            cmd_wdata_q    <= 16'h0000;
            rx_shift_q     <= 16'h0000;
            mdc_q          <= 1'b0;
            tx_en_q        <= 1'b0;
            tx_data_q      <= 1'b1;
            busy_q         <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 16'h0000;
            poll_status_q  <= 16'h0000;
            poll_upd_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            phase_q        <= phase_d;
            timer_q        <= timer_d;
            poll_pending_q <= poll_pending_d;
            last_grant_q   <= last_grant_d;
            src_host_q     <= src_host_d;
            cmd_write_q    <= cmd_write_d;
            cmd_phy_q      <= cmd_phy_d;
            cmd_reg_q      <= cmd_reg_d;
            cmd_wdata_q    <= cmd_wdata_d;
            rx_shift_q     <= rx_shift_d;
            mdc_q          <= mdc_d;
            tx_en_q        <= tx_en_d;
            tx_data_q      <= tx_data_d;
            busy_q         <= busy_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            poll_status_q  <= poll_status_d;
            poll_upd_q     <= poll_upd_d;
        end
    end

    // Accept is combinational so it lands in the grant cycle itself.
    assign host_req_ready      = grant_host & ~rst;
    assign host_rsp_valid      = rsp_valid_q;
    assign host_rsp_rdata      = rsp_rdata_q;
    assign poll_status         = poll_status_q;
    assign poll_status_updated = poll_upd_q;
    assign link_up             = poll_status_q[2];
    assign busy                = busy_q;
    assign mdc                 = mdc_q;
    assign mdio_tx_en          = tx_en_q;
    assign mdio_tx_data        = tx_data_q;

endmodule

// File: tb/tb_mdio_poll_arbiter.sv
module tb_mdio_poll_arbiter;
    localparam int D    = 4;
    localparam int PI   = 1000;
    localparam int LAST = 130 * D;   // last frame cycle; DONE is LAST+1
    localparam logic [4:0] PPHY = 5'd0;
    localparam logic [4:0] PREG = 5'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req_valid, host_req_ready, host_req_write;
    logic [4:0]  host_req_phy, host_req_reg;
    logic [15:0] host_req_wdata;
    logic        host_rsp_valid;
    logic [15:0] host_rsp_rdata;
    logic        poll_enable;
    logic [15:0] poll_status;
    logic        poll_status_updated, link_up, busy;
    logic        mdc, mdio_tx_en, mdio_tx_data, mdio_rx_data;

    always #5 clk = ~clk;

    mdio_poll_arbiter #(
        .CLK_DIV(D), .POLL_INTERVAL(PI), .POLL_PHY_ADDR(PPHY), .POLL_REG_ADDR(PREG)
    ) dut (
        .clk(clk), .rst(rst),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_write(host_req_write), .host_req_phy(host_req_phy),
        .host_req_reg(host_req_reg), .host_req_wdata(host_req_wdata),
        .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata),
        .poll_enable(poll_enable), .poll_status(poll_status),
        .poll_status_updated(poll_status_updated), .link_up(link_up),
        .busy(busy), .mdc(mdc), .mdio_tx_en(mdio_tx_en),
        .mdio_tx_data(mdio_tx_data), .mdio_rx_data(mdio_rx_data)
    );

    int errors = 0;
    int checks = 0;
    bit exp_en[65];
    bit exp_dat[65];
    logic [63:0] last_obs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected pin levels per slot, built field by field as a bit stream.
    task automatic build_model(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                               input logic [15:0] wd);
        bit q[$];
        q = {};
        for (int i = 0; i < 32; i++) q.push_back(1'b1);
        q.push_back(1'b0); q.push_back(1'b1);
        q.push_back(!wr);  q.push_back(wr);
        for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
        for (int i = 4; i >= 0; i--) q.push_back(rg[i]);
        if (wr) begin
            q.push_back(1'b1); q.push_back(1'b0);
            for (int i = 15; i >= 0; i--) q.push_back(wd[i]);
        end else begin
            for (int i = 0; i < 18; i++) q.push_back(1'b1);
        end
        q.push_back(1'b1);
        for (int k = 0; k < 65; k++) begin
            exp_dat[k] = q[k];
            exp_en[k]  = (k < (wr ? 64 : 46));
        end
    endtask

    // Present a host command at the next negedge; expect immediate accept.
    task automatic start_host(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                              input logic [15:0] wd, input string tag);
        @(negedge clk);
        host_req_valid = 1'b1;
        host_req_write = wr;
        host_req_phy   = phy;
        host_req_reg   = rg;
        host_req_wdata = wd;
        #1;
        chk({tag, "_accept"}, host_req_ready, 1'b1);
    endtask

    // Called in the grant cycle; walks cycles 1..LAST+1 acting as the PHY.
    task automatic run_frame(input bit is_host, input bit wr, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [15:0] wd,
                             input logic [15:0] rd, input int drop_at, input string tag);
        int pin_err = 0;
        int flag_err = 0;
        int en_slots = 0;
        int k, off;
        logic [63:0] obs = '0;
        build_model(wr, phy, rg, wd);
        for (int t = 1; t <= LAST + 1; t++) begin
            @(negedge clk);
            if (t == 1 && is_host) host_req_valid = 1'b0;
            if (t == drop_at) poll_enable = 1'b0;
            k   = (t - 1) / (2 * D);
            off = (t - 1) % (2 * D);
            if (!wr && k >= 48 && k <= 63) mdio_rx_data = rd[63 - k];
            else mdio_rx_data = 1'($urandom_range(0, 1));
            if (t <= LAST) begin
                if (mdc !== (off >= D)) pin_err++;
                if (mdio_tx_en !== exp_en[k]) pin_err++;
                if (mdio_tx_data !== exp_dat[k]) pin_err++;
                if (off == 0 && k < 64) begin
                    obs[63 - k] = mdio_tx_data;
                    if (mdio_tx_en) en_slots++;
                end
            end
            if (busy !== 1'b1) flag_err++;
            if (host_req_ready !== 1'b0) flag_err++;
            if (host_rsp_valid !== (t == LAST + 1 && is_host)) flag_err++;
            if (poll_status_updated !== (t == LAST + 1 && !is_host)) flag_err++;
        end
        chk({tag, "_pins"}, pin_err, 0);
        chk({tag, "_flags"}, flag_err, 0);
        chk({tag, "_en_slots"}, en_slots, wr ? 64 : 46);
        if (is_host) begin
            chk({tag, "_rdata"}, host_rsp_rdata, wr ? 16'h0000 : rd);
        end else begin
            chk({tag, "_status"}, poll_status, rd);
            chk({tag, "_link"}, link_up, rd[2]);
        end
        last_obs = obs;
    endtask

    initial begin
        logic [4:0]  rphy, rreg;
        logic [15:0] rwd, rrd;
        logic [15:0] prd;
        bit          rwr;
        int          bad;

        rst = 1'b1;
        host_req_valid = 1'b0; host_req_write = 1'b0;
        host_req_phy = 5'd0; host_req_reg = 5'd0; host_req_wdata = 16'h0;
        poll_enable = 1'b0; mdio_rx_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mdc", mdc, 1'b0);
        chk("rst_tx_en", mdio_tx_en, 1'b0);
        chk("rst_tx_data", mdio_tx_data, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", host_req_ready, 1'b0);
        chk("rst_rsp", {host_rsp_valid, host_rsp_rdata}, 17'h0);
        chk("rst_poll", {poll_status_updated, link_up, poll_status}, 18'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed write from the test plan, with a literal pin pattern.
        start_host(1'b1, 5'd3, 5'd0, 16'h1140, "wr");
        run_frame(1'b1, 1'b1, 5'd3, 5'd0, 16'h1140, 16'h0, 0, "wr");
        chk("wr_pattern", last_obs, 64'hFFFF_FFFF_5182_1140);
        @(negedge clk);
        chk("wr_idle_busy", busy, 1'b0);
        chk("wr_rsp_pulse", host_rsp_valid, 1'b0);

        // Directed read.
        start_host(1'b0, 5'd1, 5'd2, 16'h0, "rd");
        run_frame(1'b1, 1'b0, 5'd1, 5'd2, 16'h0, 16'h0141, 0, "rd");
        @(negedge clk);
        chk("rd_hold", host_rsp_rdata, 16'h0141);

        // Random back-to-back host commands (grant in the first IDLE cycle).
        for (int n = 0; n < 5; n++) begin
            rwr  = 1'($urandom_range(0, 1));
            rphy = 5'($urandom); rreg = 5'($urandom);
            rwd  = 16'($urandom); rrd = 16'($urandom);
            start_host(rwr, rphy, rreg, rwd, "rand");
            run_frame(1'b1, rwr, rphy, rreg, rwd, rrd, 0, "rand");
        end

        // Poll: first frame starts POLL_INTERVAL cycles after enable.
        @(negedge clk);
        poll_enable = 1'b1;
        repeat (PI) @(negedge clk);
        chk("poll_pre_busy", busy, 1'b0);
        run_frame(1'b0, 1'b0, PPHY, PREG, 16'h0, 16'h796D, 0, "poll");
        @(negedge clk);
        poll_enable = 1'b0;
        bad = 0;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            if (busy !== 1'b0 || poll_status_updated !== 1'b0) bad++;
        end
        chk("poll_quiet", bad, 0);
        chk("poll_status_hold", poll_status, 16'h796D);

        // Tie after reset: host, then poll, then host again.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        poll_enable = 1'b1;
        repeat (PI - 1) @(negedge clk);
        start_host(1'b1, 5'd9, 5'd17, 16'hA5C3, "tie1");
        run_frame(1'b1, 1'b1, 5'd9, 5'd17, 16'hA5C3, 16'h0, 0, "tie1");
        @(negedge clk);
        host_req_valid = 1'b1; host_req_write = 1'b0;
        host_req_phy = 5'd30; host_req_reg = 5'd5;
        #1;
        chk("tie2_no_accept", host_req_ready, 1'b0);
        prd = 16'($urandom);
        run_frame(1'b0, 1'b0, PPHY, PREG, 16'h0, prd, 0, "tie2");
        @(negedge clk);
        #1;
        chk("tie3_accept", host_req_ready, 1'b1);
        rrd = 16'($urandom);
        run_frame(1'b1, 1'b0, 5'd30, 5'd5, 16'h0, rrd, 0, "tie3");
        poll_enable = 1'b0;

        // poll_enable dropped mid poll frame.
        repeat (3) @(negedge clk);
        poll_enable = 1'b1;
        repeat (PI) @(negedge clk);
        chk("drop_pre_busy", busy, 1'b0);
        prd = 16'($urandom);
        run_frame(1'b0, 1'b0, PPHY, PREG, 16'h0, prd, 100, "drop");
        bad = 0;
        for (int t = 0; t < 2500; t++) begin
            @(negedge clk);
            if (busy !== 1'b0 || poll_status_updated !== 1'b0) bad++;
        end
        chk("drop_quiet", bad, 0);

        // Reset during slot 40 of a host read.
        start_host(1'b0, 5'd1, 5'd2, 16'h0, "rstmid");
        for (int t = 1; t <= 1 + 80 * D + 1; t++) begin
            @(negedge clk);
            if (t == 1) host_req_valid = 1'b0;
            mdio_rx_data = 1'($urandom_range(0, 1));
        end
        chk("rstmid_pre_en", mdio_tx_en, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_tx_en", mdio_tx_en, 1'b0);
        chk("rstmid_pins", {mdc, mdio_tx_data, busy}, 3'b010);
        chk("rstmid_outs", {host_rsp_valid, host_rsp_rdata, poll_status, link_up}, 34'h0);
        rst = 1'b0;
        bad = 0;
        for (int t = 0; t < 1200; t++) begin
            @(negedge clk);
            if ({mdc, mdio_tx_en, mdio_tx_data, busy, host_rsp_valid, poll_status_updated} !== 6'b001000)
                bad++;
            if (host_rsp_rdata !== 16'h0 || poll_status !== 16'h0) bad++;
        end
        chk("rstmid_quiet", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
